// File: rtl/spi_controller.sv
// SPI mode-0 write-frame controller: one 16-bit {rw, addr, data} frame per accepted command, MSB first.
// Optional SPI_ADDR_CHECK_EN: commands with cmd_addr > MAX_ADDR are accepted but dropped with an err pulse.
module spi_controller #(
    parameter int unsigned CLK_DIV  = 5,
    parameter int unsigned CS_GAP   = 4,
    parameter int unsigned MAX_ADDR = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic [6:0] cmd_addr,
    input  logic [7:0] cmd_data,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       spi_sclk,
    output logic       spi_copi,
    output logic       spi_cs
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOW,
        S_HIGH,
        S_HOLD,
        S_GAP
    } state_t;

    state_t      state, state_nx;
    logic [7:0]  cnt, cnt_nx;
    logic [3:0]  bit_cnt, bit_cnt_nx;
    logic [15:0] frame, frame_nx;
    logic        sclk_nx, copi_nx, cs_nx, done_nx, err_nx;
    logic        accept, addr_ok, last_div, last_gap;

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign accept    = cmd_valid & cmd_ready;
    assign last_div  = (cnt == 8'(CLK_DIV - 1));
    assign last_gap  = (cnt == 8'(CS_GAP - 1));

`ifdef SPI_ADDR_CHECK_EN
    assign addr_ok = (cmd_addr <= 7'(MAX_ADDR));
`else
    logic unused_addr_limit;
    assign unused_addr_limit = (cmd_addr <= 7'(MAX_ADDR));
    assign addr_ok = 1'b1;
`endif

    // Output values are computed one cycle ahead so every SPI pin is a flop.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt + 8'd1;
        bit_cnt_nx = bit_cnt;
        frame_nx   = frame;
        sclk_nx    = spi_sclk;
        copi_nx    = spi_copi;
        cs_nx      = spi_cs;
        done_nx    = 1'b0;
        err_nx     = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_nx = '0;
                if (accept) begin
                    if (addr_ok) begin
                        frame_nx   = {cmd_rw, cmd_addr, cmd_data};
                        bit_cnt_nx = 4'd15;
                        state_nx   = S_LOW;
                        cs_nx      = 1'b0;
                        copi_nx    = cmd_rw;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            end
            S_LOW: begin
                if (last_div) begin
                    state_nx = S_HIGH;
                    cnt_nx   = '0;
                    sclk_nx  = 1'b1;
                end
            end
            S_HIGH: begin
                if (last_div) begin
                    cnt_nx  = '0;
                    sclk_nx = 1'b0;
                    if (bit_cnt == 4'd0) begin
                        state_nx = S_HOLD;
                    end else begin
                        bit_cnt_nx = bit_cnt - 4'd1;
                        copi_nx    = frame[bit_cnt - 4'd1];
                        state_nx   = S_LOW;
                    end
                end
            end
            S_HOLD: begin
                if (last_div) begin
                    state_nx = S_GAP;
                    cnt_nx   = '0;
                    cs_nx    = 1'b1;
                    copi_nx  = 1'b0;
                    done_nx  = 1'b1;
                end
            end
            S_GAP: begin
                if (last_gap) begin
                    state_nx = S_IDLE;
                    cnt_nx   = '0;
                end
            end
            default: begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            bit_cnt  <= '0;
            frame    <= '0;
            spi_sclk <= 1'b0;
            spi_copi <= 1'b0;
            spi_cs   <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            bit_cnt  <= bit_cnt_nx;
            frame    <= frame_nx;
            spi_sclk <= sclk_nx;
            spi_copi <= copi_nx;
            spi_cs   <= cs_nx;
            done     <= done_nx;
            err      <= err_nx;
        end
    end

endmodule
